// File: rtl/cyclotron_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cyclotron_mem_bridge
// Description : Per-lane bridge between a multi-lane core data port and a
//               multi-lane memory port.
//               - Each lane has a REQ_DEPTH-entry in-order request FIFO with
//                 no bypass.
//               - Each lane has a single response output register.
//               - An in-flight limiter caps accepted-but-unanswered requests.
//               - A drain FSM (RUN/DRAIN/DONE) reports when the core has
//                 finished and the bridge is fully empty.
// Ports       : clock, reset             sole clock, sync active-high reset
//               core_req_*  (in)         per-lane requests from the core
//               mem_req_*   (out)        per-lane requests to memory
//               mem_resp_*  (in)         per-lane responses from memory
//               core_resp_* (out)        per-lane responses to the core
//               core_finished (in)       core reports program end
//               finished    (out)        drained and done (registered)
//               protocol_error (out)     sticky: response with no request
//               perf_req_count, perf_stall_cycles (out, optional)
// Options     : CYCLOTRON_BRIDGE_PERF_EN adds saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cyclotron_mem_bridge #(
  parameter int NUM_LANES      = 16,
  parameter int ARCH_LEN       = 32,
  parameter int DMEM_DATA_BITS = 32,
  parameter int DMEM_TAG_BITS  = 32,
  parameter int REQ_DEPTH      = 4,
  parameter int MAX_INFLIGHT   = 8,
  localparam int SIZE_BITS     = $clog2($clog2(DMEM_DATA_BITS/8)+1),
  localparam int MASK_BITS     = DMEM_DATA_BITS/8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_LANES-1:0]                core_req_valid,
  output logic [NUM_LANES-1:0]                core_req_ready,
  input  logic [NUM_LANES-1:0]                core_req_bits_store,
  input  logic [NUM_LANES*ARCH_LEN-1:0]       core_req_bits_address,
  input  logic [NUM_LANES*SIZE_BITS-1:0]      core_req_bits_size,
  input  logic [NUM_LANES*DMEM_TAG_BITS-1:0]  core_req_bits_tag,
  input  logic [NUM_LANES*DMEM_DATA_BITS-1:0] core_req_bits_data,
  input  logic [NUM_LANES*MASK_BITS-1:0]      core_req_bits_mask,
  output logic [NUM_LANES-1:0]                mem_req_valid,
  input  logic [NUM_LANES-1:0]                mem_req_ready,
  output logic [NUM_LANES-1:0]                mem_req_bits_store,
  output logic [NUM_LANES*ARCH_LEN-1:0]       mem_req_bits_address,
  output logic [NUM_LANES*SIZE_BITS-1:0]      mem_req_bits_size,
  output logic [NUM_LANES*DMEM_TAG_BITS-1:0]  mem_req_bits_tag,
  output logic [NUM_LANES*DMEM_DATA_BITS-1:0] mem_req_bits_data,
  output logic [NUM_LANES*MASK_BITS-1:0]      mem_req_bits_mask,
  input  logic [NUM_LANES-1:0]                mem_resp_valid,
  output logic [NUM_LANES-1:0]                mem_resp_ready,
  input  logic [NUM_LANES*DMEM_TAG_BITS-1:0]  mem_resp_bits_tag,
  input  logic [NUM_LANES*DMEM_DATA_BITS-1:0] mem_resp_bits_data,
  output logic [NUM_LANES-1:0]                core_resp_valid,
  input  logic [NUM_LANES-1:0]                core_resp_ready,
  output logic [NUM_LANES*DMEM_TAG_BITS-1:0]  core_resp_bits_tag,
  output logic [NUM_LANES*DMEM_DATA_BITS-1:0] core_resp_bits_data,
  input  logic                                core_finished,
  output logic                                finished,
  output logic                                protocol_error
`ifdef CYCLOTRON_BRIDGE_PERF_EN
  ,
  output logic [31:0]                         perf_req_count,
  output logic [31:0]                         perf_stall_cycles
`endif
);

  localparam int ENTRY_BITS = 1 + ARCH_LEN + SIZE_BITS + DMEM_TAG_BITS + DMEM_DATA_BITS + MASK_BITS;
  localparam int PTR_BITS   = $clog2(REQ_DEPTH);
  localparam int CNT_BITS   = PTR_BITS + 1;
  localparam int INFL_BITS  = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_BITS-1:0]  DEPTH_CNT = CNT_BITS'(REQ_DEPTH);
  localparam logic [INFL_BITS-1:0] INFL_MAX  = INFL_BITS'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state;

  logic [NUM_LANES-1:0] req_fire;       // core request accepted
  logic [NUM_LANES-1:0] issue_fire;     // request handed to memory
  logic [NUM_LANES-1:0] resp_fire;      // memory response captured
  logic [NUM_LANES-1:0] deliver_fire;   // response handed to core
  logic [NUM_LANES-1:0] lane_err;       // unexpected response this cycle
  logic [NUM_LANES-1:0] lane_idle_next; // lane empty once this cycle retires
  logic                 drain_next;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [ENTRY_BITS-1:0]     fifo_q [REQ_DEPTH];
    logic [CNT_BITS-1:0]       wr_ptr, rd_ptr, count, count_next;
    logic [INFL_BITS-1:0]      inflight, inflight_next;
    logic                      resp_valid, resp_valid_next, resp_unexp, dec;
    logic [DMEM_TAG_BITS-1:0]  resp_tag;
    logic [DMEM_DATA_BITS-1:0] resp_data;
    logic [ENTRY_BITS-1:0]     wr_entry, rd_entry;

    assign wr_entry = {core_req_bits_store[l],
                       core_req_bits_address[ARCH_LEN*l +: ARCH_LEN],
                       core_req_bits_size[SIZE_BITS*l +: SIZE_BITS],
                       core_req_bits_tag[DMEM_TAG_BITS*l +: DMEM_TAG_BITS],
                       core_req_bits_data[DMEM_DATA_BITS*l +: DMEM_DATA_BITS],
                       core_req_bits_mask[MASK_BITS*l +: MASK_BITS]};
    assign rd_entry = fifo_q[rd_ptr[PTR_BITS-1:0]];
    assign {mem_req_bits_store[l],
            mem_req_bits_address[ARCH_LEN*l +: ARCH_LEN],
            mem_req_bits_size[SIZE_BITS*l +: SIZE_BITS],
            mem_req_bits_tag[DMEM_TAG_BITS*l +: DMEM_TAG_BITS],
            mem_req_bits_data[DMEM_DATA_BITS*l +: DMEM_DATA_BITS],
            mem_req_bits_mask[MASK_BITS*l +: MASK_BITS]} = rd_entry;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count            = wr_ptr - rd_ptr;
    assign mem_req_valid[l] = (count != '0);
    // A full FIFO refuses even when it dequeues this cycle (no pass-through).
    assign core_req_ready[l] = !reset && (count != DEPTH_CNT) &&
                               (inflight < INFL_MAX) && (state != ST_DONE);
    assign req_fire[l]      = core_req_valid[l] & core_req_ready[l];
    assign issue_fire[l]    = mem_req_valid[l] & mem_req_ready[l];

    assign mem_resp_ready[l] = !reset && (!resp_valid || core_resp_ready[l]);
    assign resp_fire[l]      = mem_resp_valid[l] & mem_resp_ready[l];
    assign deliver_fire[l]   = resp_valid & core_resp_ready[l];
    assign lane_err[l]       = resp_fire[l] && (inflight == '0) && !resp_valid;

    assign core_resp_valid[l]                                     = resp_valid;
    assign core_resp_bits_tag[DMEM_TAG_BITS*l +: DMEM_TAG_BITS]   = resp_tag;
    assign core_resp_bits_data[DMEM_DATA_BITS*l +: DMEM_DATA_BITS] = resp_data;

    // Responses that arrived with nothing outstanding must not consume a
    // later legitimate request's in-flight credit when delivered.
    assign dec = deliver_fire[l] && !resp_unexp && (inflight != '0);

    always_comb begin
      inflight_next = inflight;
      if (req_fire[l] && !dec)
        inflight_next = inflight + 1'b1;
      else if (!req_fire[l] && dec)
        inflight_next = inflight - 1'b1;
    end

    always_comb begin
      count_next = count;
      if (req_fire[l] && !issue_fire[l])
        count_next = count + 1'b1;
      else if (!req_fire[l] && issue_fire[l])
        count_next = count - 1'b1;
    end

    assign resp_valid_next   = resp_fire[l] ? 1'b1 : (deliver_fire[l] ? 1'b0 : resp_valid);
    assign lane_idle_next[l] = (count_next == '0) && (inflight_next == '0) && !resp_valid_next;

    always_ff @(posedge clock) begin
      if (reset) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        inflight   <= '0;
        resp_valid <= 1'b0;
        resp_unexp <= 1'b0;
      end else begin
        if (req_fire[l])   wr_ptr <= wr_ptr + 1'b1;
        if (issue_fire[l]) rd_ptr <= rd_ptr + 1'b1;
        inflight   <= inflight_next;
        resp_valid <= resp_valid_next;
        if (resp_fire[l]) resp_unexp <= lane_err[l];
      end
    end

    // Payload storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
      if (req_fire[l]) fifo_q[wr_ptr[PTR_BITS-1:0]] <= wr_entry;
      if (resp_fire[l]) begin
        resp_tag  <= mem_resp_bits_tag[DMEM_TAG_BITS*l +: DMEM_TAG_BITS];
        resp_data <= mem_resp_bits_data[DMEM_DATA_BITS*l +: DMEM_DATA_BITS];
      end
    end
  end

  // Drain is judged on next-cycle contents so finished rises the cycle right
  // after the last response is delivered.
  assign drain_next = &lane_idle_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_RUN;
      finished       <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      if (|lane_err) protocol_error <= 1'b1;
      case (state)
        ST_RUN: begin
          if (core_finished) begin
            if (drain_next) begin
              state    <= ST_DONE;
              finished <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_next) begin
            state    <= ST_DONE;
            finished <= 1'b1;
          end
        end
        default: begin
          state    <= ST_DONE;
          finished <= 1'b1;
        end
      endcase
    end
  end

`ifdef CYCLOTRON_BRIDGE_PERF_EN
  localparam int FC_BITS = $clog2(NUM_LANES + 1);
  logic [FC_BITS-1:0] fire_cnt;
  logic [32:0]        req_sum;
  logic               any_stall;

  always_comb begin
    fire_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++)
      fire_cnt = fire_cnt + FC_BITS'(req_fire[i]);
  end

  assign req_sum   = {1'b0, perf_req_count} + 33'(fire_cnt);
  assign any_stall = |(core_req_valid & ~core_req_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_req_count    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_req_count <= req_sum[32] ? 32'hFFFF_FFFF : req_sum[31:0];
      if (any_stall && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cyclotron_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cyclotron_mem_bridge
// Description : Directed self-checking bench for cyclotron_mem_bridge
//               (4 lanes, 4-deep FIFOs, in-flight limit 6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cyclotron_mem_bridge;
  localparam int NL = 4, AL = 32, DB = 32, TB = 32, SB = 2, MB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NL-1:0]    core_req_valid, core_req_ready, core_req_bits_store;
  logic [NL*AL-1:0] core_req_bits_address;
  logic [NL*SB-1:0] core_req_bits_size;
  logic [NL*TB-1:0] core_req_bits_tag;
  logic [NL*DB-1:0] core_req_bits_data;
  logic [NL*MB-1:0] core_req_bits_mask;
  logic [NL-1:0]    mem_req_valid, mem_req_ready, mem_req_bits_store;
  logic [NL*AL-1:0] mem_req_bits_address;
  logic [NL*SB-1:0] mem_req_bits_size;
  logic [NL*TB-1:0] mem_req_bits_tag;
  logic [NL*DB-1:0] mem_req_bits_data;
  logic [NL*MB-1:0] mem_req_bits_mask;
  logic [NL-1:0]    mem_resp_valid, mem_resp_ready;
  logic [NL*TB-1:0] mem_resp_bits_tag;
  logic [NL*DB-1:0] mem_resp_bits_data;
  logic [NL-1:0]    core_resp_valid, core_resp_ready;
  logic [NL*TB-1:0] core_resp_bits_tag;
  logic [NL*DB-1:0] core_resp_bits_data;
  logic             core_finished, finished, protocol_error;
`ifdef CYCLOTRON_BRIDGE_PERF_EN
  logic [31:0]      perf_req_count, perf_stall_cycles;
`endif

  int tests  = 0;
  int failed = 0;
  int acc;

  cyclotron_mem_bridge #(
    .NUM_LANES(NL), .ARCH_LEN(AL), .DMEM_DATA_BITS(DB), .DMEM_TAG_BITS(TB),
    .REQ_DEPTH(4), .MAX_INFLIGHT(6)
  ) dut (
    .clock(clock), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_bits_store(core_req_bits_store), .core_req_bits_address(core_req_bits_address),
    .core_req_bits_size(core_req_bits_size), .core_req_bits_tag(core_req_bits_tag),
    .core_req_bits_data(core_req_bits_data), .core_req_bits_mask(core_req_bits_mask),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_bits_store(mem_req_bits_store), .mem_req_bits_address(mem_req_bits_address),
    .mem_req_bits_size(mem_req_bits_size), .mem_req_bits_tag(mem_req_bits_tag),
    .mem_req_bits_data(mem_req_bits_data), .mem_req_bits_mask(mem_req_bits_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_bits_tag(mem_resp_bits_tag), .mem_resp_bits_data(mem_resp_bits_data),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_bits_tag(core_resp_bits_tag), .core_resp_bits_data(core_resp_bits_data),
    .core_finished(core_finished), .finished(finished), .protocol_error(protocol_error)
`ifdef CYCLOTRON_BRIDGE_PERF_EN
    , .perf_req_count(perf_req_count), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked on
  // the falling edge of the same cycle.
  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic drive_req(input int l, input logic v, input logic [31:0] addr,
                           input logic [31:0] tag, input logic [31:0] data);
    core_req_valid[l]               = v;
    core_req_bits_store[l]          = 1'b0;
    core_req_bits_address[l*AL +: AL] = addr;
    core_req_bits_size[l*SB +: SB]  = 2'd2;
    core_req_bits_tag[l*TB +: TB]   = tag;
    core_req_bits_data[l*DB +: DB]  = data;
    core_req_bits_mask[l*MB +: MB]  = 4'hF;
  endtask

  task automatic drive_resp(input int l, input logic v, input logic [31:0] tag, input logic [31:0] data);
    mem_resp_valid[l]              = v;
    mem_resp_bits_tag[l*TB +: TB]  = tag;
    mem_resp_bits_data[l*DB +: DB] = data;
  endtask

  task automatic defaults();
    core_req_valid = '0; core_req_bits_store = '0; core_req_bits_address = '0;
    core_req_bits_size = '0; core_req_bits_tag = '0; core_req_bits_data = '0;
    core_req_bits_mask = '0; mem_req_ready = '1; mem_resp_valid = '0;
    mem_resp_bits_tag = '0; mem_resp_bits_data = '0; core_resp_ready = '1;
    core_finished = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle(); reset = 1'b1; defaults();
    next_cycle(); reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    defaults();
    // Reset state
    next_cycle(); reset = 1'b1; settle();
    check_val("rst_creq_rdy", core_req_ready, 4'h0);
    check_val("rst_mresp_rdy", mem_resp_ready, 4'h0);
    next_cycle(); reset = 1'b0; settle();
    check_val("rst_mreq_vld", mem_req_valid, 4'h0);
    check_val("rst_cresp_vld", core_resp_valid, 4'h0);
    check_val("rst_finished", finished, 0);
    check_val("rst_perr", protocol_error, 0);
    check_val("rst_creq_rdy_after", core_req_ready, 4'hF);

    // Single load round trip on lane 0
    next_cycle(); drive_req(0, 1, 32'h1000, 5, 0); settle();
    check_val("a_creq_rdy", core_req_ready[0], 1);
    check_val("a_nobypass", mem_req_valid[0], 0);
    next_cycle(); drive_req(0, 0, 0, 0, 0); settle();
    check_val("a_mreq_vld", mem_req_valid[0], 1);
    check_val("a_mreq_addr", mem_req_bits_address[0 +: AL], 32'h1000);
    check_val("a_mreq_tag", mem_req_bits_tag[0 +: TB], 5);
    next_cycle(); settle();
    check_val("a_mreq_popped", mem_req_valid[0], 0);
    next_cycle(); drive_resp(0, 1, 5, 32'hDEADBEEF); settle();
    check_val("a_mresp_rdy", mem_resp_ready[0], 1);
    check_val("a_cresp_early", core_resp_valid[0], 0);
    next_cycle(); drive_resp(0, 0, 0, 0); settle();
    check_val("a_cresp_vld", core_resp_valid[0], 1);
    check_val("a_cresp_tag", core_resp_bits_tag[0 +: TB], 5);
    check_val("a_cresp_data", core_resp_bits_data[0 +: DB], 32'hDEADBEEF);
    next_cycle(); settle();
    check_val("a_cresp_gone", core_resp_valid[0], 0);
    check_val("a_perr", protocol_error, 0);

    // FIFO full on lane 2, then ordered release
    do_reset(); mem_req_ready[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_req(2, 1, 32'h2000 + 32'(i * 4), 32'h20 + 32'(i), 32'h100 + 32'(i));
      settle();
      check_val($sformatf("b_rdy%0d", i), core_req_ready[2], (i < 4) ? 1 : 0);
      next_cycle();
    end
    mem_req_ready[2] = 1'b1; settle();
    check_val("b_full_noacc", core_req_ready[2], 0);
    check_val("b_head0", mem_req_bits_tag[2*TB +: TB], 32'h20);
    next_cycle(); settle();
    check_val("b_5th_acc", core_req_ready[2], 1);
    check_val("b_head1", mem_req_bits_tag[2*TB +: TB], 32'h21);
    next_cycle(); drive_req(2, 0, 0, 0, 0);
    for (int k = 2; k < 5; k++) begin
      settle();
      check_val($sformatf("b_head%0d", k), mem_req_bits_tag[2*TB +: TB], 32'h20 + 32'(k));
      check_val($sformatf("b_addr%0d", k), mem_req_bits_address[2*AL +: AL], 32'h2000 + 32'(k * 4));
      next_cycle();
    end
    settle();
    check_val("b_empty", mem_req_valid[2], 0);

    // In-flight limit on lane 1
    do_reset(); acc = 0;
    drive_req(1, 1, 32'h3000, 32'h40, 0);
    for (int i = 0; i < 9; i++) begin
      settle();
      if (core_req_ready[1]) acc++;
      next_cycle();
    end
    settle();
    check_val("c_accepted", acc, 6);
    check_val("c_blocked", core_req_ready[1], 0);
    next_cycle(); drive_resp(1, 1, 32'h40, 32'h55); settle();
    check_val("c_mresp_rdy", mem_resp_ready[1], 1);
    next_cycle(); drive_resp(1, 0, 0, 0); settle();
    check_val("c_cresp_vld", core_resp_valid[1], 1);
    check_val("c_still_blocked", core_req_ready[1], 0);
    next_cycle(); settle();
    check_val("c_rdy_back", core_req_ready[1], 1);
    next_cycle(); drive_req(1, 0, 0, 0, 0);

    // Drain with two outstanding on lane 3
    do_reset();
    drive_req(3, 1, 32'h4000, 32'h31, 0); settle(); next_cycle();
    drive_req(3, 1, 32'h4004, 32'h32, 0); settle(); next_cycle();
    drive_req(3, 0, 0, 0, 0); settle(); next_cycle();
    core_finished = 1'b1; settle();
    check_val("d_fin_run", finished, 0);
    next_cycle(); core_finished = 1'b0; settle();
    check_val("d_fin_drain", finished, 0);
    check_val("d_drain_rdy", core_req_ready[3], 1);
    next_cycle(); drive_resp(3, 1, 32'h31, 32'hA1); settle(); next_cycle();
    drive_resp(3, 0, 0, 0); settle();
    check_val("d_resp1_tag", core_resp_bits_tag[3*TB +: TB], 32'h31);
    check_val("d_fin_one", finished, 0);
    next_cycle(); drive_resp(3, 1, 32'h32, 32'hA2); settle(); next_cycle();
    drive_resp(3, 0, 0, 0); core_resp_ready[3] = 1'b0; settle();
    check_val("d_resp2_vld", core_resp_valid[3], 1);
    check_val("d_fin_held", finished, 0);
    next_cycle(); core_resp_ready[3] = 1'b1; settle();
    check_val("d_fin_fire", finished, 0);
    next_cycle(); settle();
    check_val("d_finished", finished, 1);
    check_val("d_done_rdy", core_req_ready, 4'h0);
    next_cycle(); settle();
    check_val("d_fin_sticky", finished, 1);

    // Reset discards queued requests; stray response flags an error
    do_reset(); mem_req_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(0, 1, 32'h5000, 32'h50 + 32'(i), 0); settle(); next_cycle();
    end
    drive_req(0, 0, 0, 0, 0); reset = 1'b1; settle(); next_cycle();
    reset = 1'b0; settle();
    check_val("e_mreq_vld", mem_req_valid[0], 0);
    check_val("e_creq_rdy", core_req_ready, 4'hF);
    check_val("e_finished", finished, 0);
    check_val("e_perr0", protocol_error, 0);
    mem_req_ready[0] = 1'b1;
    next_cycle(); drive_resp(0, 1, 32'h77, 32'h99); settle();
    check_val("e_perr_pre", protocol_error, 0);
    next_cycle(); drive_resp(0, 0, 0, 0); settle();
    check_val("e_perr_set", protocol_error, 1);
    check_val("e_fwd_vld", core_resp_valid[0], 1);
    check_val("e_fwd_tag", core_resp_bits_tag[0 +: TB], 32'h77);
    next_cycle(); settle();
    check_val("e_perr_sticky", protocol_error, 1);

    // Direct RUN -> DONE when already idle
    do_reset(); core_finished = 1'b1; settle();
    check_val("f_perr_clr", protocol_error, 0);
    check_val("f_fin_pre", finished, 0);
    next_cycle(); core_finished = 1'b0; settle();
    check_val("f_finished", finished, 1);
    check_val("f_done_rdy", core_req_ready, 4'h0);

`ifdef CYCLOTRON_BRIDGE_PERF_EN
    // 10 accepted requests, 3 stalled cycles
    do_reset(); mem_req_ready[0] = 1'b0;
    drive_req(0, 1, 32'h6000, 32'h60, 0);
    for (int i = 0; i < 7; i++) begin settle(); next_cycle(); end
    drive_req(0, 0, 0, 0, 0); drive_req(2, 1, 32'h7000, 32'h70, 0);
    for (int i = 0; i < 6; i++) begin settle(); next_cycle(); end
    drive_req(2, 0, 0, 0, 0); settle();
    check_val("p_req_count", perf_req_count, 10);
    check_val("p_stall_cycles", perf_stall_cycles, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire
